// File: rtl/eth_st_pkg.sv
// Shared Avalon-ST Ethernet-path constants and helpers for the 32-to-8 width adapter.
package eth_st_pkg;

    localparam int SYMBOL_W    = 8;
    localparam int ETH_SYMBOLS = 4;
    localparam int ETH_EMPTY_W = 2;

    localparam logic [ETH_EMPTY_W-1:0] LAST_SYM = ETH_EMPTY_W'(ETH_SYMBOLS - 1);

    typedef logic [ETH_SYMBOLS-1:0][SYMBOL_W-1:0] sym_word_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Index of the final valid symbol in a beat; empty only matters on the EOP beat.
    function automatic logic [ETH_EMPTY_W-1:0] last_sym_idx(
        input logic                   eop,
        input logic [ETH_EMPTY_W-1:0] empty
    );
        return eop ? (LAST_SYM - empty) : LAST_SYM;
    endfunction

endpackage

// File: rtl/eth_st_width_down_32to8_if.sv
// Upstream 32-bit and downstream 8-bit Avalon-ST streams of the width-down adapter.
interface eth_st_width_down_32to8_if;
    import eth_st_pkg::*;

    logic                            in_valid;
    logic                            in_ready;
    logic [SYMBOL_W*ETH_SYMBOLS-1:0] in_data;
    logic                            in_sop;
    logic                            in_eop;
    logic [ETH_EMPTY_W-1:0]          in_empty;

    logic                            out_valid;
    logic                            out_ready;
    logic [SYMBOL_W-1:0]             out_data;
    logic                            out_sop;
    logic                            out_eop;

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, in_empty, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop
    );

    modport master (
        output in_valid, in_data, in_sop, in_eop, in_empty, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop
    );

endinterface

// File: rtl/eth_st_width_down_32to8.sv
// Serialises 4-symbol Avalon-ST beats into single-byte beats, honouring empty on the EOP beat.
// state    | meaning
// ST_EMPTY | no word held, ready for a new beat
// ST_SHIFT | word held, presenting symbol r_idx
module eth_st_width_down_32to8
    import eth_st_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_reset,
    eth_st_width_down_32to8_if.slave  io_st
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ETH_EMPTY_W-1:0] r_idx;
    logic [ETH_EMPTY_W-1:0] w_idx_nxt;
    logic [ETH_EMPTY_W-1:0] r_last_idx;
    logic [ETH_EMPTY_W-1:0] w_last_idx_nxt;
    logic                   r_sop;
    logic                   w_sop_nxt;
    logic                   r_eop;
    logic                   w_eop_nxt;
    sym_word_t              r_word;

    logic                   w_full;
    logic                   w_on_last;
    logic                   w_in_ready;
    logic                   w_load;
    logic                   w_advance;
    logic [ETH_EMPTY_W-1:0] w_sel;

    assign w_full     = (r_state == ST_SHIFT);
    assign w_on_last  = (r_idx == r_last_idx);
    // Ready looks through out_ready so a new word can replace the last symbol without a bubble.
    assign w_in_ready = !w_full || (io_st.out_ready && w_on_last);
    assign w_load     = io_st.in_valid && w_in_ready;
    assign w_advance  = w_full && io_st.out_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_last_idx_nxt = r_last_idx;
        w_sop_nxt      = r_sop;
        w_eop_nxt      = r_eop;
        if (w_load) begin
            w_state_nxt    = ST_SHIFT;
            w_idx_nxt      = '0;
            w_last_idx_nxt = last_sym_idx(io_st.in_eop, io_st.in_empty);
            w_sop_nxt      = io_st.in_sop;
            w_eop_nxt      = io_st.in_eop;
        end else if (w_advance) begin
            if (!w_on_last) begin
                w_idx_nxt = r_idx + ETH_EMPTY_W'(1);
            end else begin
                w_state_nxt = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_EMPTY;
            r_idx      <= '0;
            r_last_idx <= LAST_SYM;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_last_idx <= w_last_idx_nxt;
            r_sop      <= w_sop_nxt;
            r_eop      <= w_eop_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_load) begin
            r_word <= io_st.in_data;
        end
    end

    // Symbol 0 sits in the MSBs, which is the highest packed index.
    assign w_sel = LAST_SYM - r_idx;

    assign io_st.in_ready  = w_in_ready;
    assign io_st.out_valid = w_full;
    assign io_st.out_data  = r_word[w_sel];
    assign io_st.out_sop   = w_full && r_sop && (r_idx == '0);
    assign io_st.out_eop   = w_full && r_eop && w_on_last;

endmodule
